// File: rtl/lsu_pkg.sv
// Shared definitions for the M-stage load/store unit.
//   - lsu_op_e     : encoding of the m_op port
//   - lsu_state_e  : bus FSM states
//   - MASK_*       : byte-enable masks per access size, before lane shifting
//   - op_* helpers : classify an op and check its alignment
package lsu_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LW   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LHU  = 4'd3,
        LSU_LB   = 4'd4,
        LSU_LBU  = 4'd5,
        LSU_SW   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SB   = 4'd8
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LD_REQ  = 2'd2,
        ST_LD_DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] MASK_B = 4'h1;
    localparam logic [3:0] MASK_H = 4'h3;
    localparam logic [3:0] MASK_W = 4'hF;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == LSU_LW) || (op == LSU_LH) || (op == LSU_LHU) ||
               (op == LSU_LB) || (op == LSU_LBU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == LSU_SW) || (op == LSU_SH) || (op == LSU_SB);
    endfunction

    function automatic logic [3:0] op_mask(input logic [3:0] op);
        case (op)
            LSU_LW, LSU_SW:          return MASK_W;
            LSU_LH, LSU_LHU, LSU_SH: return MASK_H;
            default:                 return MASK_B;
        endcase
    endfunction

    // Words need addr[1:0]==0, halves addr[0]==0, bytes are always aligned.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            LSU_LW, LSU_SW:          return a != 2'b00;
            LSU_LH, LSU_LHU, LSU_SH: return a[0];
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/m_stage_lsu_store_fifo.sv
// In-order store buffer: synchronous FIFO with a registered count.
//   clk, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i/din_i : enqueue din_i when not full
//   pop_i        : drop the head entry when not empty
//   full_o, empty_o, head_o, count_o : status and head-of-queue entry
// Pointers wrap naturally modulo DEPTH (power of two); full/empty come from count.
module lsu_store_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Full refuses a push even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/m_stage_lsu.sv
// M-stage load/store unit. Stores are buffered in an in-order FIFO and drained
// to the bus; loads wait for the FIFO to empty, then perform one bus read.
//   M stage : m_valid, m_op, m_addr, m_wdata in; lsu_stall, ld_valid, ld_data,
//             exc_adel, exc_ades out
//   Bus     : bus_req/we/addr/byteen/wdata out, bus_ack/bus_rdata in
//   Debug   : dbg_state (FSM state), dbg_sb_count (store-buffer occupancy)
// Bus handshake: bus_req rises with addr/we/byteen/wdata and all of them hold
// steady until the cycle bus_ack is high; that cycle completes the transfer
// (and carries bus_rdata on reads). One transfer outstanding at most; only a
// reset can withdraw a request.
module m_stage_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      m_valid,
    input  logic [3:0]                m_op,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [31:0]               m_wdata,
    output logic                      lsu_stall,
    output logic                      ld_valid,
    output logic [31:0]               ld_data,
    output logic                      exc_adel,
    output logic                      exc_ades,
    output logic                      bus_req,
    output logic                      bus_we,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W/8-1:0]       bus_byteen,
    output logic [DATA_W-1:0]         bus_wdata,
    input  logic                      bus_ack,
    input  logic [DATA_W-1:0]         bus_rdata,
    output logic [1:0]                dbg_state,
    output logic [$clog2(SB_DEPTH):0] dbg_sb_count
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int ENT_W = ADDR_W + BE_W + DATA_W;

    lsu_state_e state_q, state_d;

    // M-stage decode and lane placement
    logic              is_ld, is_st, misal, ld_ok, st_ok;
    logic [OFS_W-1:0]  ofs;
    logic [BE_W-1:0]   be_m;
    logic [DATA_W-1:0] wdata_m;
    logic [ADDR_W-1:0] addr_al;

    assign is_ld   = op_is_load(m_op);
    assign is_st   = op_is_store(m_op);
    assign misal   = op_misaligned(m_op, m_addr[1:0]);
    assign ld_ok   = m_valid & is_ld & ~misal;
    assign st_ok   = m_valid & is_st & ~misal;
    assign exc_adel = m_valid & is_ld & misal;
    assign exc_ades = m_valid & is_st & misal;

    assign ofs     = m_addr[OFS_W-1:0];
    assign be_m    = BE_W'(op_mask(m_op)) << ofs;
    assign wdata_m = DATA_W'(m_wdata) << {ofs, 3'b000};
    assign addr_al = {m_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

    // Store buffer
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] hd_addr;
    logic [BE_W-1:0]   hd_be;
    logic [DATA_W-1:0] hd_wdata;
    logic [$clog2(SB_DEPTH):0] fifo_count;

    assign fifo_push = st_ok & ~fifo_full;
    assign fifo_pop  = (state_q == ST_DRAIN) & bus_ack;
    assign {hd_addr, hd_be, hd_wdata} = head;

    lsu_store_fifo #(.W(ENT_W), .DEPTH(SB_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({addr_al, be_m, wdata_m}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head),
        .count_o (fifo_count)
    );

    // Load request registers: captured when the read starts so the bus side
    // stays stable independently of the M-stage inputs.
    logic              load_start;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [BE_W-1:0]   ld_be_q;
    logic [OFS_W-1:0]  ld_ofs_q;
    logic [3:0]        ld_op_q;
    logic [31:0]       ld_data_q, ld_data_d, ld_ext, lane32;

    assign load_start = (state_q == ST_IDLE) & fifo_empty & ld_ok;

    // Shift the addressed lane down to bit 0, then extend per load type.
    assign lane32 = 32'(bus_rdata >> {ld_ofs_q, 3'b000});

    always_comb begin
        ld_ext = lane32;
        case (ld_op_q)
            LSU_LB:  ld_ext = {{24{lane32[7]}}, lane32[7:0]};
            LSU_LBU: ld_ext = {24'b0, lane32[7:0]};
            LSU_LH:  ld_ext = {{16{lane32[15]}}, lane32[15:0]};
            LSU_LHU: ld_ext = {16'b0, lane32[15:0]};
            default: ld_ext = lane32;
        endcase
    end

    assign ld_data_d = ((state_q == ST_LD_REQ) && bus_ack) ? ld_ext : ld_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_addr_q <= '0;
            ld_be_q   <= '0;
            ld_ofs_q  <= '0;
            ld_op_q   <= LSU_NONE;
            ld_data_q <= '0;
        end else begin
            if (load_start) begin
                ld_addr_q <= addr_al;
                ld_be_q   <= be_m;
                ld_ofs_q  <= ofs;
                ld_op_q   <= m_op;
            end
            ld_data_q <= ld_data_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state. Pending stores always go before a load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty)  state_d = ST_DRAIN;
                else if (ld_ok)   state_d = ST_LD_REQ;
            end
            ST_DRAIN: begin
                // Leave only when the last entry pops and nothing refills it.
                if (bus_ack && (fifo_count == 1) && !fifo_push) state_d = ST_IDLE;
            end
            ST_LD_REQ:  if (bus_ack) state_d = ST_LD_DONE;
            ST_LD_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_byteen = '0;
        bus_wdata  = '0;
        ld_valid   = 1'b0;
        case (state_q)
            ST_DRAIN: begin
                bus_req    = 1'b1;
                bus_we     = 1'b1;
                bus_addr   = hd_addr;
                bus_byteen = hd_be;
                bus_wdata  = hd_wdata;
            end
            ST_LD_REQ: begin
                bus_req    = 1'b1;
                bus_addr   = ld_addr_q;
                bus_byteen = ld_be_q;
            end
            ST_LD_DONE: ld_valid = 1'b1;
            default: ;
        endcase
        // A load holds the pipe until the cycle it retires; a store only when full.
        lsu_stall = (ld_ok & (state_q != ST_LD_DONE)) | (st_ok & fifo_full);
    end

    assign ld_data      = ld_data_q;
    assign dbg_state    = state_q;
    assign dbg_sb_count = fifo_count;

endmodule

// File: tb/tb_m_stage_lsu.sv
module tb_m_stage_lsu;
  import lsu_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // 32-bit instance signals
  logic        m_valid, bus_ack;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_wdata, bus_rdata;
  logic        lsu_stall, ld_valid, exc_adel, exc_ades, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_sb_count;

  // 64-bit instance signals
  logic        m_valid64, bus_ack64;
  logic [3:0]  m_op64;
  logic [31:0] m_addr64, m_wdata64;
  logic [63:0] bus_rdata64;
  logic        lsu_stall64, ld_valid64, exc_adel64, exc_ades64, bus_req64, bus_we64;
  logic [31:0] ld_data64, bus_addr64;
  logic [63:0] bus_wdata64;
  logic [7:0]  bus_byteen64;
  logic [1:0]  dbg_state64;
  logic [2:0]  dbg_sb_count64;

  m_stage_lsu #(.DATA_W(32), .ADDR_W(32), .SB_DEPTH(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_wdata(m_wdata), .lsu_stall(lsu_stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dbg_state(dbg_state),
    .dbg_sb_count(dbg_sb_count)
  );

  m_stage_lsu #(.DATA_W(64), .ADDR_W(32), .SB_DEPTH(4)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .m_valid(m_valid64), .m_op(m_op64), .m_addr(m_addr64),
    .m_wdata(m_wdata64), .lsu_stall(lsu_stall64), .ld_valid(ld_valid64), .ld_data(ld_data64),
    .exc_adel(exc_adel64), .exc_ades(exc_ades64), .bus_req(bus_req64), .bus_we(bus_we64),
    .bus_addr(bus_addr64), .bus_byteen(bus_byteen64), .bus_wdata(bus_wdata64),
    .bus_ack(bus_ack64), .bus_rdata(bus_rdata64), .dbg_state(dbg_state64),
    .dbg_sb_count(dbg_sb_count64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    m_valid = v; m_op = op; m_addr = a; m_wdata = d;
  endtask

  // Load with an empty store buffer and a 1-cycle ack.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    drive(1'b1, op, a, 32'h0);
    #1;
    check({tag, "_stall"}, lsu_stall, 1'b1);
    step();
    check({tag, "_req"}, bus_req, 1'b1);
    check({tag, "_we"}, bus_we, 1'b0);
    check({tag, "_addr"}, bus_addr, a & 32'hFFFF_FFFC);
    bus_ack = 1'b1; bus_rdata = rdata;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    check({tag, "_ldv"}, ld_valid, 1'b1);
    check({tag, "_data"}, ld_data, exp);
    check({tag, "_nostall"}, lsu_stall, 1'b0);
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    step();
    check({tag, "_ldv_off"}, ld_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    m_valid64 = 1'b0; m_op64 = LSU_NONE; m_addr64 = 32'h0; m_wdata64 = 32'h0;
    bus_ack64 = 1'b0; bus_rdata64 = 64'h0;
    step(); step();
    check("rst_req", bus_req, 1'b0);
    check("rst_ldv", ld_valid, 1'b0);
    check("rst_stall", lsu_stall, 1'b0);
    check("rst_ldd", ld_data, 32'h0);
    check("rst_cnt", dbg_sb_count, 3'd0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    step();

    // 1: sb 0xAB @0x1003, ack after 2 cycles
    drive(1'b1, LSU_SB, 32'h1003, 32'h0000_00AB);
    #1;
    check("t1_stall", lsu_stall, 1'b0);
    check("t1_exc", {exc_adel, exc_ades}, 2'b00);
    step();
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    check("t1_cnt", dbg_sb_count, 3'd1);
    step();
    check("t1_req", bus_req, 1'b1);
    check("t1_we", bus_we, 1'b1);
    check("t1_addr", bus_addr, 32'h1000);
    check("t1_be", bus_byteen, 4'b1000);
    check("t1_wdata", bus_wdata, 32'hAB00_0000);
    step();
    check("t1_hold_req", bus_req, 1'b1);
    check("t1_hold_be", bus_byteen, 4'b1000);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("t1_done_req", bus_req, 1'b0);
    check("t1_done_cnt", dbg_sb_count, 3'd0);

    // 2: five back-to-back sw, ack held low
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, LSU_SW, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i));
      #1;
      check($sformatf("t2_nostall%0d", i), lsu_stall, 1'b0);
      step();
    end
    check("t2_full_cnt", dbg_sb_count, 3'd4);
    drive(1'b1, LSU_SW, 32'h110, 32'hA004);
    #1;
    check("t2_stall", lsu_stall, 1'b1);
    check("t2_head_addr", bus_addr, 32'h100);
    check("t2_head_wdata", bus_wdata, 32'hA000);
    step();
    check("t2_stall_hold", lsu_stall, 1'b1);
    check("t2_cnt_hold", dbg_sb_count, 3'd4);
    bus_ack = 1'b1;
    #1;
    check("t2_stall_on_ack", lsu_stall, 1'b1);
    step();
    bus_ack = 1'b0;
    #1;
    check("t2_cnt_after_pop", dbg_sb_count, 3'd3);
    check("t2_stall_released", lsu_stall, 1'b0);
    step();
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    check("t2_cnt_refill", dbg_sb_count, 3'd4);
    bus_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t2_drain_req%0d", i), bus_req, 1'b1);
      check($sformatf("t2_drain_addr%0d", i), bus_addr, 32'h104 + 32'(4 * i));
      check($sformatf("t2_drain_wdata%0d", i), bus_wdata, 32'hA001 + 32'(i));
      step();
    end
    bus_ack = 1'b0;
    check("t2_empty", dbg_sb_count, 3'd0);
    check("t2_idle", dbg_state, ST_IDLE);

    // 3: sw then lb to the same word; read only after the write completes
    drive(1'b1, LSU_SW, 32'h20, 32'h1234_5678);
    step();
    drive(1'b1, LSU_LB, 32'h23, 32'h0);
    #1;
    check("t3_ld_wait_stall", lsu_stall, 1'b1);
    step();
    check("t3_wr_req", bus_req, 1'b1);
    check("t3_wr_we", bus_we, 1'b1);
    check("t3_wr_addr", bus_addr, 32'h20);
    check("t3_wr_wdata", bus_wdata, 32'h1234_5678);
    check("t3_wr_be", bus_byteen, 4'hF);
    check("t3_stall_drain", lsu_stall, 1'b1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("t3_gap_req", bus_req, 1'b0);
    check("t3_gap_stall", lsu_stall, 1'b1);
    step();
    check("t3_rd_req", bus_req, 1'b1);
    check("t3_rd_we", bus_we, 1'b0);
    check("t3_rd_addr", bus_addr, 32'h20);
    check("t3_rd_be", bus_byteen, 4'b1000);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check("t3_ldv", ld_valid, 1'b1);
    check("t3_data", ld_data, 32'h0000_0012);
    check("t3_stall_off", lsu_stall, 1'b0);
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    step();
    check("t3_ldv_off", ld_valid, 1'b0);
    check("t3_data_hold", ld_data, 32'h0000_0012);

    do_load("lb80",  LSU_LB,  32'h23, 32'h8056_3412, 32'hFFFF_FF80);
    do_load("lbu80", LSU_LBU, 32'h23, 32'h8056_3412, 32'h0000_0080);
    do_load("lh",    LSU_LH,  32'h22, 32'h8001_3412, 32'hFFFF_8001);
    do_load("lhu",   LSU_LHU, 32'h22, 32'h8001_3412, 32'h0000_8001);
    do_load("lb1",   LSU_LB,  32'h41, 32'h0000_7F00, 32'h0000_007F);
    do_load("lw",    LSU_LW,  32'h40, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // 4: misaligned accesses
    drive(1'b1, LSU_LW, 32'h1002, 32'h0);
    #1;
    check("t4_adel", exc_adel, 1'b1);
    check("t4_adel_ades", exc_ades, 1'b0);
    check("t4_adel_stall", lsu_stall, 1'b0);
    step();
    check("t4_adel_req", bus_req, 1'b0);
    check("t4_adel_state", dbg_state, ST_IDLE);
    drive(1'b1, LSU_SH, 32'h1001, 32'h5555);
    #1;
    check("t4_ades", exc_ades, 1'b1);
    check("t4_ades_adel", exc_adel, 1'b0);
    check("t4_ades_stall", lsu_stall, 1'b0);
    step();
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    check("t4_ades_cnt", dbg_sb_count, 3'd0);
    step();
    check("t4_ades_req", bus_req, 1'b0);

    // 5: 64-bit bus, sh 0xBEEF @0x06
    m_valid64 = 1'b1; m_op64 = LSU_SH; m_addr64 = 32'h6; m_wdata64 = 32'h0000_BEEF;
    #1;
    check("t5_stall", lsu_stall64, 1'b0);
    step();
    m_valid64 = 1'b0; m_op64 = LSU_NONE;
    step();
    check("t5_req", bus_req64, 1'b1);
    check("t5_be", bus_byteen64, 8'hC0);
    check("t5_wdata", bus_wdata64, 64'hBEEF_0000_0000_0000);
    check("t5_addr", bus_addr64, 32'h0);
    bus_ack64 = 1'b1;
    step();
    bus_ack64 = 1'b0;
    check("t5_cnt", dbg_sb_count64, 3'd0);

    // 6a: reset while draining a store
    drive(1'b1, LSU_SW, 32'h80, 32'h1111_2222);
    step();
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    step();
    check("t6a_req", bus_req, 1'b1);
    reset_n = 1'b0;
    step();
    check("t6a_req_drop", bus_req, 1'b0);
    check("t6a_cnt", dbg_sb_count, 3'd0);
    check("t6a_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;

    // 6b: reset during LD_REQ, then a late ack
    drive(1'b1, LSU_LW, 32'h40, 32'h0);
    step();
    check("t6b_req", bus_req, 1'b1);
    check("t6b_state", dbg_state, ST_LD_REQ);
    reset_n = 1'b0;
    drive(1'b0, LSU_NONE, 32'h0, 32'h0);
    step();
    check("t6b_req_drop", bus_req, 1'b0);
    check("t6b_stall", lsu_stall, 1'b0);
    check("t6b_cnt", dbg_sb_count, 3'd0);
    check("t6b_ldd", ld_data, 32'h0);
    reset_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check("t6b_late_state", dbg_state, ST_IDLE);
    check("t6b_late_ldv", ld_valid, 1'b0);
    check("t6b_late_ldd", ld_data, 32'h0);
    check("t6b_late_req", bus_req, 1'b0);
    step();
    check("t6b_final_ldv", ld_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
